// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: data width, opcodes and sequencer state encoding.
package cpu_pkg;

   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] OP_LOAD3 = 8'h01;
   localparam logic [DATA_W-1:0] OP_ADD9  = 8'h02;
   localparam logic [DATA_W-1:0] OP_HALT  = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4,
      ST_PAUSE  = 3'd5
   } state_t;

   // Only these opcodes commit the ALU result; everything else behaves as a NOP.
   function automatic logic writes_acc(input logic [DATA_W-1:0] op);
      return (op == OP_LOAD3) || (op == OP_ADD9);
   endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; owns PC, IR, ACC and the retire count.
// Build option CPU_SEQ_STEP_EN adds a `step` input and a PAUSE state after every EXEC.
//
// state  | meaning
// IDLE   | waiting for start; no fetch outstanding
// FETCH  | imem_req held at imem_addr=pc until imem_valid, then IR captured
// DECODE | one settling cycle for decode/ALU, no register updates
// EXEC   | commit ACC (LOAD3/ADD9), advance PC, count the retire
// PAUSE  | single-step hold after EXEC, released by step (CPU_SEQ_STEP_EN only)
// HALT   | terminal; everything frozen until rst_n
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef CPU_SEQ_STEP_EN
   input  logic              step,
`endif
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_valid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] ir,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] acc,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   state_t state;

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pc       <= '0;
         ir       <= '0;
         acc      <= '0;
         retired  <= '0;
         imem_req <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FETCH;
                  pc       <= '0;
                  acc      <= '0;
                  retired  <= '0;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (ir == OP_HALT) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (writes_acc(ir))
                  acc <= alu_result;
               pc      <= pc + PC_W'(1);
               retired <= retired + CNT_W'(1);
`ifdef CPU_SEQ_STEP_EN
               state   <= ST_PAUSE;
`else
               state    <= ST_FETCH;
               imem_req <= 1'b1;
`endif
            end
`ifdef CPU_SEQ_STEP_EN
            ST_PAUSE: begin
               if (step) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
`endif
            ST_HALT: begin
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
               busy     <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: program table with per-retire scoreboard plus hand-written corner sequences.
module tb_cpu_seq_ctrl;
   import cpu_pkg::*;

   localparam int PC_W  = 2;
   localparam int CNT_W = 8;
`ifdef CPU_SEQ_STEP_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 3;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_valid = 1'b0;
   logic [7:0]        imem_rdata = 8'h00;
   logic [7:0]        ir;
   logic [7:0]        alu_result;
   logic [7:0]        acc;
   logic [PC_W-1:0]   pc;
   logic              busy;
   logic              halted;
   logic [CNT_W-1:0]  retired;
`ifdef CPU_SEQ_STEP_EN
   logic              step = 1'b0;
`endif

   cpu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CPU_SEQ_STEP_EN
      .step(step),
`endif
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .ir(ir), .alu_result(alu_result), .acc(acc),
      .pc(pc), .busy(busy), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   // Environment: ALU and instruction memory with configurable wait states.
   always_comb begin
      alu_result = acc;
      if (ir == 8'h01) alu_result = 8'd3;
      else if (ir == 8'h02) alu_result = acc + 8'd9;
   end

   logic [7:0] mem [4];
   int wait_cfg = 0;
   int wait_cnt = 0;

   always @(posedge clk) begin
      #2;
      if (imem_req) begin
         if (wait_cnt >= wait_cfg) begin
            imem_valid = 1'b1;
            imem_rdata = mem[imem_addr];
         end else begin
            imem_valid = 1'b0;
            wait_cnt++;
         end
      end else begin
         imem_valid = 1'b0;
         wait_cnt = 0;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct {
      logic [3:0][7:0] prog;
      int              wt;
      int              stop_at;
      bit              mid_start;
      logic [7:0]      exp_acc;
      logic [1:0]      exp_pc;
      logic [7:0]      exp_ret;
      bit              exp_halt;
   } vec_t;

   typedef struct {
      logic [7:0] acc;
      logic [1:0] pc;
      logic [7:0] ret;
   } sb_t;

   sb_t  sbq[$];
   vec_t vecs[5];

   // Reference model: expected architectural state after every retire.
   task automatic push_expected(input vec_t v);
      logic [7:0] a = 8'h00;
      logic [1:0] p = 2'd0;
      logic [7:0] r = 8'h00;
      logic [7:0] op;
      for (int k = 0; k < 16; k++) begin
         op = v.prog[p];
         if (op == 8'hFF) break;
         if (op == 8'h01) a = 8'd3;
         else if (op == 8'h02) a = a + 8'd9;
         p = p + 2'd1;
         r = r + 8'd1;
         sbq.push_back('{acc: a, pc: p, ret: r});
         if (v.stop_at != 0 && int'(r) == v.stop_at) break;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      sb_t e;
      logic [7:0] prev_ret;
      int cyc, last;
      bit done;
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = v.prog[i];
      wait_cfg = v.wt;
      sbq.delete();
      push_expected(v);
      pulse_start();
      prev_ret = 8'h00;
      cyc = 0;
      last = 0;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         start = 1'b0;
         @(negedge clk);
         cyc++;
         if (retired != prev_ret) begin
            if (sbq.size() == 0) begin
               chk($sformatf("v%0d_unexpected_retire", idx), retired, prev_ret);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("v%0d_acc", idx), acc, e.acc);
               chk($sformatf("v%0d_pc", idx), pc, e.pc);
               chk($sformatf("v%0d_retired", idx), retired, e.ret);
            end
            if (v.wt == 0 && prev_ret != 0)
               chk($sformatf("v%0d_gap", idx), cyc - last, GAP);
            last = cyc;
            prev_ret = retired;
            if (v.mid_start && retired == 8'd2) start = 1'b1;
         end
         if (halted || (v.stop_at != 0 && int'(retired) >= v.stop_at)) done = 1'b1;
      end
      start = 1'b0;
      chk($sformatf("v%0d_timeout", idx), done, 1);
      chk($sformatf("v%0d_sb_left", idx), sbq.size(), 0);
      chk($sformatf("v%0d_final_acc", idx), acc, v.exp_acc);
      chk($sformatf("v%0d_final_pc", idx), pc, v.exp_pc);
      chk($sformatf("v%0d_final_ret", idx), retired, v.exp_ret);
      chk($sformatf("v%0d_halted", idx), halted, v.exp_halt);
      chk($sformatf("v%0d_busy", idx), busy, !v.exp_halt);
   endtask

   initial begin
      vecs[0] = '{prog: {8'hFF, 8'h02, 8'h02, 8'h01}, wt: 0, stop_at: 0, mid_start: 0,
                  exp_acc: 8'd21, exp_pc: 2'd3, exp_ret: 8'd3, exp_halt: 1};
      vecs[1] = '{prog: {8'h00, 8'h00, 8'hFF, 8'h55}, wt: 0, stop_at: 0, mid_start: 0,
                  exp_acc: 8'd0, exp_pc: 2'd1, exp_ret: 8'd1, exp_halt: 1};
      vecs[2] = '{prog: {8'h00, 8'hFF, 8'h02, 8'h01}, wt: 2, stop_at: 0, mid_start: 0,
                  exp_acc: 8'd12, exp_pc: 2'd2, exp_ret: 8'd2, exp_halt: 1};
      vecs[3] = '{prog: {8'h02, 8'h02, 8'h02, 8'h02}, wt: 0, stop_at: 4, mid_start: 1,
                  exp_acc: 8'd36, exp_pc: 2'd0, exp_ret: 8'd4, exp_halt: 0};
      vecs[4] = '{prog: {8'hFF, 8'h01, 8'h33, 8'h02}, wt: 1, stop_at: 0, mid_start: 0,
                  exp_acc: 8'd3, exp_pc: 2'd3, exp_ret: 8'd3, exp_halt: 1};
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;

`ifdef CPU_SEQ_STEP_EN
      step = 1'b1;
`endif
      do_reset();
      chk("rst_req", imem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_acc_pc_ir_ret", {acc, ir, retired, 6'd0, pc}, 0);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Wait states: request and address stable, IR loads only on the valid cycle.
      do_reset();
      mem[0] = 8'h01; mem[1] = 8'hFF; mem[2] = 8'h00; mem[3] = 8'h00;
      wait_cfg = 4;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         chk("ws_req", imem_req, 1);
         chk("ws_addr", imem_addr, 0);
         chk("ws_ir_hold", ir, 0);
         @(negedge clk);
      end
      chk("ws_req_valid_cycle", imem_req, 1);
      chk("ws_ir_before_valid", ir, 0);
      @(negedge clk);
      chk("ws_ir_loaded", ir, 8'h01);
      chk("ws_req_dropped", imem_req, 0);

      // Asynchronous reset while a fetch is outstanding.
      do_reset();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h02; mem[3] = 8'h02;
      wait_cfg = 0;
      pulse_start();
      begin
         int t;
         for (t = 0; t < 50 && retired != 8'd1; t++) @(negedge clk);
         wait_cfg = 50;
         for (t = 0; t < 50 && retired != 8'd2; t++) @(negedge clk);
         chk("mf_reach_ret2", retired, 2);
      end
      @(negedge clk);
      chk("mf_req_pending", imem_req, 1);
      chk("mf_acc_before", acc, 8'd12);
      #1 rst_n = 1'b0;
      #1;
      chk("mf_req_async", imem_req, 0);
      chk("mf_acc_async", acc, 0);
      chk("mf_pc_async", pc, 0);
      chk("mf_busy_async", busy, 0);
      chk("mf_ret_async", retired, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("mf_stays_idle", imem_req, 0);
      wait_cfg = 0;

`ifdef CPU_SEQ_STEP_EN
      // Single-step: PAUSE after every EXEC, released only by step.
      step = 1'b0;
      do_reset();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hFF; mem[3] = 8'h00;
      pulse_start();
      for (int t = 0; t < 50 && retired != 8'd1; t++) @(negedge clk);
      chk("st_acc1", acc, 8'd3);
      repeat (3) @(negedge clk);
      chk("st_pause_ret", retired, 1);
      chk("st_pause_req", imem_req, 0);
      chk("st_pause_busy", busy, 1);
      step = 1'b1;
      @(negedge clk);
      chk("st_fetch_req", imem_req, 1);
      @(negedge clk);
      step = 1'b0;
      for (int t = 0; t < 50 && retired != 8'd2; t++) @(negedge clk);
      chk("st_acc2", acc, 8'd12);
      chk("st_ret2", retired, 2);
      repeat (3) @(negedge clk);
      chk("st_pause2_req", imem_req, 0);
      chk("st_pause2_halt", halted, 0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      chk("st_halted", halted, 1);
      chk("st_final_ret", retired, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
